csr_file: RTL and testbench
===========================

# csr_file

Machine-mode CSR register file and trap sequencer for the core. It consumes decoded CSR requests (funct, 12-bit address, operand) and exception reports from the execute/exception stage. It returns read data registered for `csr_except` writeback and sequences trap entry and `mret` into a PC redirect for fetch. It also owns the cycle/instret counters.

## Interface
- `RESET_MTVEC`, default 32'h0000_0100: mtvec reset value.
- `clk` in 1: core clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `csr_valid` in 1: CSR instruction request, single-cycle pulse.
- `csr_funct` in 3: funct3 of SYSTEM opcode: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- `csr_addr` in 12: CSR address.
- `csr_wdata` in `REG_DATA_SIZE`+1: rs1 value, or zero-extended zimm.
- `csr_wr_suppress` in 1: rs1/zimm field is zero for RS/RC forms; no write occurs.
- `trap_valid` in 1: exception taken, single-cycle pulse.
- `trap_cause` in `EX_WIDTH`+1: exception code.
- `trap_pc` in 32: PC of faulting instruction.
- `trap_tval` in 32: mtval value.
- `mret_valid` in 1: MRET retiring.
- `instret` in 1: one instruction retired this cycle.
- `csr_rdata` out 32: old CSR value.
- `csr_rdata_valid` out 1: `csr_rdata` valid, one-cycle pulse.
- `csr_illegal` out 1: access illegal, one-cycle pulse.
- `redirect_valid` out 1: fetch must load `redirect_pc`, one-cycle pulse.
- `redirect_pc` out 32: target PC.
- `busy` out 1: sequencer not IDLE; upstream stalls and must not present new requests.

## Operation
- Implemented CSRs:
  - mstatus 0x300: MIE bit 3, MPIE bit 7, MPP[12:11] hardwired 2'b11; other bits read 0.
  - mie 0x304, mip 0x344: read 0, writes ignored.
  - mtvec 0x305: direct mode; bits[1:0] read 0.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342: bit 31 = 0; low bits = `trap_cause` zero-extended.
  - mtval 0x343.
  - misa 0x301: RO 0x40000100.
  - mvendorid, marchid, mimpid, mhartid 0xF11–0xF14: RO 0.
- Write value: RW → wdata; RS → old|wdata; RC → old&~wdata.
- `csr_wr_suppress` with RS/RC: read only, no write side effects.
- Illegal, when any holds:
  - funct 000 or 100;
  - unimplemented address;
  - write attempt to a read-only address (addr[11:10]==2'b11) unless suppressed.
- Illegal access: `csr_illegal`=1, `csr_rdata_valid`=0, no state change.
- State machine:
  - IDLE: `trap_valid` → TRAP. Else `mret_valid` → MRET. Else service `csr_valid`.
  - TRAP, one cycle: mepc←trap_pc, mcause←cause, mtval←trap_tval, MPIE←MIE, MIE←0. Next state REDIR_T.
  - REDIR_T: `redirect_valid`=1, `redirect_pc`=mtvec. Next state IDLE.
  - MRET: MIE←MPIE, MPIE←1, `redirect_valid`=1, `redirect_pc`=mepc. Next state IDLE.
- Simultaneous inputs, priority trap > mret > csr. A `csr_valid` lost to priority is discarded; no response is produced.
- Inputs arriving while `busy`=1 are ignored.

## Timing
- CSR access: request at cycle N. `csr_rdata`/`csr_rdata_valid`/`csr_illegal` registered at N+1. CSR write visible to a request issued at N+1.
- Trap: `trap_valid` at N, `busy` at N+1..N+2, `redirect_valid` at N+2.
- mret: `mret_valid` at N, `redirect_valid` and `busy` at N+1.
- Reset values:
  - mstatus 0x00001800, mtvec `RESET_MTVEC`;
  - all other CSRs, counters and outputs 0;
  - state IDLE.
- Reset asserted mid-sequence aborts it immediately; no redirect is produced.

## Configuration
- `CSR_COUNTERS_EN` defined:
  - 64-bit mcycle (increments every cycle) and minstret (increments on `instret`).
  - Wrap 2^64-1 → 0 with no flag.
  - Addresses: mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, RO shadows cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82.
  - A CSR write to a counter half replaces that increment for that cycle.
- `CSR_COUNTERS_EN` undefined: no counter logic; all those addresses are illegal.

## Test plan
- Reset, then CSRRS 0x300 with `csr_wr_suppress`=1 → next cycle `csr_rdata`=0x00001800, valid=1.
- CSRRW mscratch 0xDEADBEEF, then CSRRC mscratch 0x0000FFFF → second read returns 0xDEADBEEF; third read returns 0xDEAD0000.
- mtvec←0x203 (reads 0x200), MIE←1, then trap cause 2, pc 0x1004 → redirect_pc 0x200 two cycles later. Afterwards mepc=0x1004, mcause=2, mstatus=0x1880.
- mret after the above → redirect_pc 0x1004 one cycle later; mstatus=0x1888.
- `trap_valid`, `mret_valid` and `csr_valid` on the same cycle → only trap sequence runs, no `csr_rdata_valid`. CSRRW to 0xF14 → `csr_illegal`=1 and no state change; address 0x7C0 → illegal.
- With `CSR_COUNTERS_EN`: write mcycle 0xFFFFFFFF and mcycleh 0xFFFFFFFF → reads wrap to 0. Write to 0xC00 → illegal. Without the macro, a read of 0xB00 → illegal.

Source files
------------

// File: rtl/csr_file_if.sv
// CSR request, trap report and fetch-redirect bundle between execute, csr_file and fetch.
interface csr_file_if #(
    parameter int REG_DATA_SIZE = 31,
    parameter int EX_WIDTH      = 4
);
    logic                   csr_valid;
    logic [2:0]             csr_funct;
    logic [11:0]            csr_addr;
    logic [REG_DATA_SIZE:0] csr_wdata;
    logic                   csr_wr_suppress;
    logic                   trap_valid;
    logic [EX_WIDTH:0]      trap_cause;
    logic [31:0]            trap_pc;
    logic [31:0]            trap_tval;
    logic                   mret_valid;
    logic                   instret;
    logic [31:0]            csr_rdata;
    logic                   csr_rdata_valid;
    logic                   csr_illegal;
    logic                   redirect_valid;
    logic [31:0]            redirect_pc;
    logic                   busy;

    modport master (
        output csr_valid, csr_funct, csr_addr, csr_wdata, csr_wr_suppress,
               trap_valid, trap_cause, trap_pc, trap_tval, mret_valid, instret,
        input  csr_rdata, csr_rdata_valid, csr_illegal, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  csr_valid, csr_funct, csr_addr, csr_wdata, csr_wr_suppress,
               trap_valid, trap_cause, trap_pc, trap_tval, mret_valid, instret,
        output csr_rdata, csr_rdata_valid, csr_illegal, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file with trap/mret sequencer producing fetch redirects.
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_file #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
    parameter int          EX_WIDTH    = 4
) (
    input logic       clk,
    input logic       rst_n,
    csr_file_if.slave bus
);
    typedef enum logic [1:0] {IDLE, TRAP, REDIR_T, MRET} state_t;
    state_t state, state_nxt;

    localparam logic [31:0] CAUSE_MASK = (32'd1 << (EX_WIDTH + 1)) - 32'd1;

    logic        mie, mpie;
    logic [31:0] mtvec, mscratch, mepc, mcause, mtval;
    logic [31:2] tpc_q;
    logic [31:0] tcause_q, tval_q;
    logic [31:0] wdata, old, wval;
    logic        hit, do_wr, legal, take_csr, take_trap, wr_en;
`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle, minstret;
`endif

    assign wdata = 32'(bus.csr_wdata);

    always_comb begin
        old = '0;
        hit = 1'b1;
        case (bus.csr_addr)
            12'h300: old = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
            12'h301: old = 32'h4000_0100;
            12'h304, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14: old = '0;
            12'h305: old = mtvec;
            12'h340: old = mscratch;
            12'h341: old = mepc;
            12'h342: old = mcause;
            12'h343: old = mtval;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: old = mcycle[31:0];
            12'hB80, 12'hC80: old = mcycle[63:32];
            12'hB02, 12'hC02: old = minstret[31:0];
            12'hB82, 12'hC82: old = minstret[63:32];
`endif
            default: hit = 1'b0;
        endcase
    end

    // Trap wins over mret, mret over csr; nothing is accepted outside IDLE.
    assign take_trap = (state == IDLE) && bus.trap_valid;
    assign take_csr  = (state == IDLE) && !bus.trap_valid && !bus.mret_valid && bus.csr_valid;
    assign do_wr     = (bus.csr_funct[1:0] == 2'b01) || !bus.csr_wr_suppress;
    assign legal     = hit && (bus.csr_funct[1:0] != 2'b00)
                       && !((bus.csr_addr[11:10] == 2'b11) && do_wr);
    assign wr_en     = take_csr && legal && do_wr;

    always_comb begin
        wval = old & ~wdata;
        case (bus.csr_funct[1:0])
            2'b01:   wval = wdata;
            2'b10:   wval = old | wdata;
            default: wval = old & ~wdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        case (state)
            IDLE: begin
                if (bus.trap_valid)      state_nxt = TRAP;
                else if (bus.mret_valid) state_nxt = MRET;
            end
            TRAP: state_nxt = REDIR_T;
            REDIR_T: begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = mtvec;
                state_nxt          = IDLE;
            end
            MRET: begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = mepc;
                state_nxt          = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie                 <= 1'b0;
            mpie                <= 1'b0;
            mtvec               <= {RESET_MTVEC[31:2], 2'b00};
            mscratch            <= '0;
            mepc                <= '0;
            mcause              <= '0;
            mtval               <= '0;
            tpc_q               <= '0;
            tcause_q            <= '0;
            tval_q              <= '0;
            bus.csr_rdata       <= '0;
            bus.csr_rdata_valid <= 1'b0;
            bus.csr_illegal     <= 1'b0;
        end else begin
            bus.csr_rdata_valid <= take_csr && legal;
            bus.csr_illegal     <= take_csr && !legal;
            if (take_csr && legal) bus.csr_rdata <= old;
            // Trap operands are single-cycle pulses, so hold them for the TRAP state.
            if (take_trap) begin
                tpc_q    <= bus.trap_pc[31:2];
                tcause_q <= 32'(bus.trap_cause);
                tval_q   <= bus.trap_tval;
            end
            if (state == TRAP) begin
                mepc   <= {tpc_q, 2'b00};
                mcause <= tcause_q & CAUSE_MASK;
                mtval  <= tval_q;
                mpie   <= mie;
                mie    <= 1'b0;
            end
            if (state == MRET) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end
            if (wr_en) begin
                case (bus.csr_addr)
                    12'h300: begin
                        mie  <= wval[3];
                        mpie <= wval[7];
                    end
                    12'h305: mtvec    <= {wval[31:2], 2'b00};
                    12'h340: mscratch <= wval;
                    12'h341: mepc     <= {wval[31:2], 2'b00};
                    12'h342: mcause   <= wval & CAUSE_MASK;
                    12'h343: mtval    <= wval;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    // A write to either half takes the place of that cycle's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (wr_en && bus.csr_addr == 12'hB00)      mcycle[31:0]  <= wval;
            else if (wr_en && bus.csr_addr == 12'hB80) mcycle[63:32] <= wval;
            else                                       mcycle        <= mcycle + 64'd1;
            if (wr_en && bus.csr_addr == 12'hB02)      minstret[31:0]  <= wval;
            else if (wr_en && bus.csr_addr == 12'hB82) minstret[63:32] <= wval;
            else if (bus.instret)                      minstret        <= minstret + 64'd1;
        end
    end
`endif
endmodule

// File: tb/tb_csr_file.sv
// Randomized bench for csr_file against a behavioural model, plus literal spot checks.
module tb_csr_file;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    bit   cmp_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    csr_file_if #(.REG_DATA_SIZE(31), .EX_WIDTH(4)) bus ();
    csr_file #(.RESET_MTVEC(32'h0000_0100), .EX_WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        bit          redir;
        logic [31:0] pc;
    } step_t;

    step_t       plan[$];
    bit          m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cyc, m_ins;
    bit          e_busy, e_redir, e_valid, e_ill;
    logic [31:0] e_pc, e_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mread(input logic [11:0] a, output logic [31:0] v);
        v = '0;
        mread = 1'b1;
        case (a)
            12'h300: v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h301: v = 32'h4000_0100;
            12'h304, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14: v = '0;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: v = m_cyc[31:0];
            12'hB80, 12'hC80: v = m_cyc[63:32];
            12'hB02, 12'hC02: v = m_ins[31:0];
            12'hB82, 12'hC82: v = m_ins[63:32];
`endif
            default: mread = 1'b0;
        endcase
    endfunction

    // Returns 1 when a cycle-counter half was written, 2 for an instret half.
    function automatic int mwrite(input logic [11:0] a, input logic [31:0] v);
        mwrite = 0;
        case (a)
            12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
            12'h305: m_mtvec    = v & ~32'd3;
            12'h340: m_mscratch = v;
            12'h341: m_mepc     = v & ~32'd3;
            12'h342: m_mcause   = v & 32'h1F;
            12'h343: m_mtval    = v;
`ifdef CSR_COUNTERS_EN
            12'hB00: begin m_cyc[31:0]  = v; mwrite = 1; end
            12'hB80: begin m_cyc[63:32] = v; mwrite = 1; end
            12'hB02: begin m_ins[31:0]  = v; mwrite = 2; end
            12'hB82: begin m_ins[63:32] = v; mwrite = 2; end
`endif
            default: ;
        endcase
    endfunction

    task automatic model_reset();
        plan.delete();
        m_mie = 0; m_mpie = 0;
        m_mtvec = 32'h100; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cyc = 0; m_ins = 0;
        e_busy = 0; e_redir = 0; e_valid = 0; e_ill = 0; e_pc = 0; e_rdata = 0;
    endtask

    task automatic model_step();
        logic [31:0] old, w, nv;
        bit ok, wr;
        int cw;
        cw = 0;
        e_valid = 0;
        e_ill = 0;
        w = bus.csr_wdata;
        if (plan.size() != 0) begin
            void'(plan.pop_front());
        end else if (bus.trap_valid) begin
            plan.push_back('{redir: 1'b0, pc: 32'd0});
            plan.push_back('{redir: 1'b1, pc: m_mtvec});
            m_mepc = bus.trap_pc & ~32'd3;
            m_mcause = 32'(bus.trap_cause);
            m_mtval = bus.trap_tval;
            m_mpie = m_mie;
            m_mie = 0;
        end else if (bus.mret_valid) begin
            plan.push_back('{redir: 1'b1, pc: m_mepc});
            m_mie = m_mpie;
            m_mpie = 1;
        end else if (bus.csr_valid) begin
            ok = mread(bus.csr_addr, old);
            if (bus.csr_funct == 3'd0 || bus.csr_funct == 3'd4) ok = 0;
            wr = (bus.csr_funct[1:0] == 2'b01) || !bus.csr_wr_suppress;
            if (bus.csr_addr >= 12'hC00 && wr) ok = 0;
            if (ok) begin
                e_valid = 1;
                e_rdata = old;
                if (wr) begin
                    if (bus.csr_funct[1:0] == 2'b01)      nv = w;
                    else if (bus.csr_funct[1:0] == 2'b10) nv = old | w;
                    else                                   nv = old & ~w;
                    cw = mwrite(bus.csr_addr, nv);
                end
            end else begin
                e_ill = 1;
            end
        end
        if (cw != 1) m_cyc = m_cyc + 64'd1;
        if (cw != 2 && bus.instret) m_ins = m_ins + 64'd1;
        e_busy  = plan.size() != 0;
        e_redir = e_busy && plan[0].redir;
        e_pc    = e_busy ? plan[0].pc : 32'd0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(bus.busy), 32'(e_busy));
            chk("redirect_valid", 32'(bus.redirect_valid), 32'(e_redir));
            chk("csr_rdata_valid", 32'(bus.csr_rdata_valid), 32'(e_valid));
            chk("csr_illegal", 32'(bus.csr_illegal), 32'(e_ill));
            if (e_redir) chk("redirect_pc", bus.redirect_pc, e_pc);
            if (e_valid) chk("csr_rdata", bus.csr_rdata, e_rdata);
        end
    end

    task automatic clr();
        bus.csr_valid = 0; bus.csr_funct = 0; bus.csr_addr = 0; bus.csr_wdata = 0;
        bus.csr_wr_suppress = 0; bus.trap_valid = 0; bus.trap_cause = 0; bus.trap_pc = 0;
        bus.trap_tval = 0; bus.mret_valid = 0; bus.instret = 0;
    endtask

    task automatic issue(input logic [2:0] f, input logic [11:0] a, input logic [31:0] w, input bit s);
        bus.csr_valid = 1; bus.csr_funct = f; bus.csr_addr = a; bus.csr_wdata = w;
        bus.csr_wr_suppress = s;
        @(negedge clk);
    endtask

    task automatic csr(input logic [2:0] f, input logic [11:0] a, input logic [31:0] w, input bit s);
        issue(f, a, w, s);
        clr();
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr(3'b010, a, 32'd0, 1'b1);
        chk({name, "_valid"}, 32'(bus.csr_rdata_valid), 32'd1);
        chk(name, bus.csr_rdata, exp);
    endtask

    task automatic trap(input logic [4:0] c, input logic [31:0] pc);
        bus.trap_valid = 1; bus.trap_cause = c; bus.trap_pc = pc; bus.trap_tval = 32'hBAD0;
        @(negedge clk);
        clr();
    endtask

    logic [11:0] addrs[20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                               12'h343, 12'h344, 12'hF11, 12'hF14, 12'h7C0, 12'hB00, 12'hB80,
                               12'hB02, 12'hB82, 12'hC00, 12'hC82, 12'hC01, 12'h000};
    logic [2:0]  rf;

    initial begin
        clr();
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        rd("mstatus_reset", 12'h300, 32'h0000_1800);
        rd("mtvec_reset", 12'h305, 32'h0000_0100);

        csr(3'b001, 12'h340, 32'hDEADBEEF, 1'b0);
        csr(3'b011, 12'h340, 32'h0000FFFF, 1'b0);
        chk("mscratch_rc_old", bus.csr_rdata, 32'hDEADBEEF);
        rd("mscratch_cleared", 12'h340, 32'hDEAD0000);

        csr(3'b001, 12'h305, 32'h203, 1'b0);
        rd("mtvec_aligned", 12'h305, 32'h200);
        csr(3'b010, 12'h300, 32'h8, 1'b0);
        trap(5'd2, 32'h1004);
        chk("trap_busy_n1", 32'(bus.busy), 32'd1);
        chk("trap_noredir_n1", 32'(bus.redirect_valid), 32'd0);
        @(negedge clk);
        chk("trap_redir_n2", 32'(bus.redirect_valid), 32'd1);
        chk("trap_pc_n2", bus.redirect_pc, 32'h200);
        @(negedge clk);
        chk("trap_idle_n3", 32'(bus.busy), 32'd0);
        rd("mepc_trap", 12'h341, 32'h1004);
        rd("mcause_trap", 12'h342, 32'd2);
        rd("mstatus_trap", 12'h300, 32'h1880);

        bus.mret_valid = 1;
        @(negedge clk);
        clr();
        chk("mret_redir", 32'(bus.redirect_valid), 32'd1);
        chk("mret_pc", bus.redirect_pc, 32'h1004);
        @(negedge clk);
        rd("mstatus_mret", 12'h300, 32'h1888);

        bus.csr_valid = 1; bus.csr_funct = 3'b001; bus.csr_addr = 12'h340; bus.csr_wdata = 32'h1234;
        bus.mret_valid = 1;
        trap(5'd3, 32'h2000);
        chk("simul_no_rdata", 32'(bus.csr_rdata_valid), 32'd0);
        @(negedge clk);
        chk("simul_redir_pc", bus.redirect_pc, 32'h200);
        @(negedge clk);
        rd("simul_mscratch_kept", 12'h340, 32'hDEAD0000);

        csr(3'b001, 12'hF14, 32'h5, 1'b0);
        chk("ro_write_illegal", 32'(bus.csr_illegal), 32'd1);
        rd("mhartid_zero", 12'hF14, 32'd0);
        csr(3'b010, 12'h7C0, 32'd0, 1'b1);
        chk("unimpl_illegal", 32'(bus.csr_illegal), 32'd1);

`ifdef CSR_COUNTERS_EN
        issue(3'b001, 12'hB00, 32'hFFFFFFFF, 1'b0);
        issue(3'b001, 12'hB80, 32'hFFFFFFFF, 1'b0);
        issue(3'b010, 12'hB80, 32'd0, 1'b1);
        chk("mcycleh_max", bus.csr_rdata, 32'hFFFFFFFF);
        issue(3'b010, 12'hB00, 32'd0, 1'b1);
        chk("mcycle_wrapped", bus.csr_rdata, 32'd0);
        issue(3'b010, 12'hB80, 32'd0, 1'b1);
        chk("mcycleh_wrapped", bus.csr_rdata, 32'd0);
        clr();
        csr(3'b001, 12'hC00, 32'd1, 1'b0);
        chk("cycle_ro_illegal", 32'(bus.csr_illegal), 32'd1);
`else
        csr(3'b010, 12'hB00, 32'd0, 1'b1);
        chk("no_counters_illegal", 32'(bus.csr_illegal), 32'd1);
`endif

        trap(5'd7, 32'h3000);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_redir", 32'(bus.redirect_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3000; i++) begin
            bus.trap_valid = $urandom_range(0, 99) < 3;
            bus.mret_valid = $urandom_range(0, 99) < 3;
            bus.trap_cause = 5'($urandom);
            bus.trap_pc    = $urandom;
            bus.trap_tval  = $urandom;
            bus.csr_valid  = 1'($urandom);
            rf             = 3'($urandom);
            bus.csr_funct  = rf;
            bus.csr_addr   = addrs[$urandom_range(0, 19)];
            bus.csr_wdata  = rf[2] ? 32'($urandom_range(0, 31)) : $urandom;
            bus.csr_wr_suppress = $urandom_range(0, 3) == 0;
            bus.instret    = 1'($urandom);
            @(negedge clk);
        end
        clr();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
